// File: rtl/sram_spi_pkg.sv
// Shared definitions for the SPI SRAM controller: instruction opcodes,
// FSM state encoding and frame geometry.
package sram_spi_pkg;

  // Default SRAM instruction opcodes
  localparam logic [7:0] SRAM_CMD_READ  = 8'h03;
  localparam logic [7:0] SRAM_CMD_WRITE = 8'h02;

  // Frame geometry: command + 2 address bytes + data byte, 8 bits each
  localparam int unsigned BYTE_CNT = 4;
  localparam int unsigned BIT_CNT  = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    RECV   = 3'd3,
    FINISH = 3'd4
  } state_t;

endpackage

// File: rtl/spi_rx_shift.sv
// Receive shifter: collects serial data from the SRAM, MSB first.
// Ports:
//   sck   - SPI clock, shifts on the falling edge
//   rst_n - asynchronous active-low reset
//   en    - shift enable
//   sdi   - serial input bit
//   data  - collected byte (most recent bit in the LSB)
module spi_rx_shift
  import sram_spi_pkg::*;
(
  input  logic               sck,
  input  logic               rst_n,
  input  logic               en,
  input  logic               sdi,
  output logic [BIT_CNT-1:0] data
);

  always_ff @(negedge sck or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (en) begin
      data <= {data[BIT_CNT-2:0], sdi};
    end
  end

endmodule

// File: rtl/sram_spi_ctrl.sv
// SPI SRAM transaction controller. Sequences the command, address and
// (for writes) data bytes into an external transmit buffer, then either
// finishes or collects one read byte from the SRAM.
// Ports:
//   sck, rst_n          - SPI clock (all state changes on negedge), async reset
//   start, rw           - transaction request and direction (1 = read)
//   addr, wdata         - byte address and write data, captured with start
//   sdi                 - serial read data from the SRAM
//   busy, done          - transaction in flight / one-cycle completion pulse
//   rdata               - last byte read, held until the next read completes
//   cs_n                - SRAM chip select, active low
//   tx_byte, load_tx    - parallel byte and load strobe for the transmit buffer
//   shift_tx, tx_count  - transmit shift enable and bit index (8..1)
module sram_spi_ctrl
  import sram_spi_pkg::*;
#(
  parameter logic [7:0] CMD_READ  = SRAM_CMD_READ,
  parameter logic [7:0] CMD_WRITE = SRAM_CMD_WRITE
) (
  input  logic        sck,
  input  logic        rst_n,
  input  logic        start,
  input  logic        rw,
  input  logic [15:0] addr,
  input  logic [7:0]  wdata,
  input  logic        sdi,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        cs_n,
  output logic [7:0]  tx_byte,
  output logic        load_tx,
  output logic        shift_tx,
  output logic [3:0]  tx_count
);

  state_t      state;
  logic        rw_q;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic [1:0]  idx;
  logic [2:0]  rx_cnt;
  logic [7:0]  rx_data;
  logic        rx_en_c;

  // Bytes after the command use the captured request
  function automatic logic [7:0] frame_byte(input logic [1:0] i);
    case (i)
      2'd0:    frame_byte = rw_q ? CMD_READ : CMD_WRITE;
      2'd1:    frame_byte = addr_q[15:8];
      2'd2:    frame_byte = addr_q[7:0];
      default: frame_byte = wdata_q;
    endcase
  endfunction

  assign rx_en_c = (state == RECV);

  spi_rx_shift u_rx (
    .sck   (sck),
    .rst_n (rst_n),
    .en    (rx_en_c),
    .sdi   (sdi),
    .data  (rx_data)
  );

  // Transaction FSM with registered outputs
  always_ff @(negedge sck or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      idx      <= '0;
      rx_cnt   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
      cs_n     <= 1'b1;
      tx_byte  <= '0;
      load_tx  <= 1'b0;
      shift_tx <= 1'b0;
      tx_count <= '0;
    end else begin
      done    <= 1'b0;
      load_tx <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            rw_q    <= rw;
            addr_q  <= addr;
            wdata_q <= wdata;
            idx     <= '0;
            busy    <= 1'b1;
            cs_n    <= 1'b0;
            // Command byte comes straight from the request being accepted
            load_tx <= 1'b1;
            tx_byte <= rw ? CMD_READ : CMD_WRITE;
            state   <= LOAD;
          end
        end
        LOAD: begin
          shift_tx <= 1'b1;
          tx_count <= 4'(BIT_CNT);
          state    <= SHIFT;
        end
        SHIFT: begin
          if (tx_count > 4'd1) begin
            tx_count <= tx_count - 4'd1;
          end else begin
            shift_tx <= 1'b0;
            tx_count <= '0;
            if (idx == 2'(BYTE_CNT - 1)) begin
              state <= FINISH;
            end else if (idx == 2'd2 && rw_q) begin
              rx_cnt <= '0;
              state  <= RECV;
            end else begin
              idx     <= idx + 2'd1;
              load_tx <= 1'b1;
              tx_byte <= frame_byte(idx + 2'd1);
              state   <= LOAD;
            end
          end
        end
        RECV: begin
          rx_cnt <= rx_cnt + 3'd1;
          if (rx_cnt == 3'(BIT_CNT - 1)) begin
            state <= FINISH;
          end
        end
        FINISH: begin
          // Completion is registered on exit so done and cs_n rise together
          if (rw_q) begin
            rdata <= rx_data;
          end
          cs_n  <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_spi_ctrl.sv
// Self-checking bench for sram_spi_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked against a cycle-offset model.
module tb_sram_spi_ctrl;

  logic        sck;
  logic        rst_n;
  logic        start;
  logic        rw;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        sdi;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic        cs_n;
  logic [7:0]  tx_byte;
  logic        load_tx;
  logic        shift_tx;
  logic [3:0]  tx_count;

  int errors = 0;
  int checks = 0;

  sram_spi_ctrl dut (
    .sck      (sck),
    .rst_n    (rst_n),
    .start    (start),
    .rw       (rw),
    .addr     (addr),
    .wdata    (wdata),
    .sdi      (sdi),
    .busy     (busy),
    .done     (done),
    .rdata    (rdata),
    .cs_n     (cs_n),
    .tx_byte  (tx_byte),
    .load_tx  (load_tx),
    .shift_tx (shift_tx),
    .tx_count (tx_count)
  );

  initial sck = 1'b1;
  always #5 sck = ~sck;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A transaction is tracked only by its cycle offset k (1 = first cycle
  // after the accepting edge); outputs follow from the frame arithmetic.
  logic [7:0]  next_rbyte = 8'h00;
  bit          m_active = 1'b0;
  int          m_k = 0;
  int          m_len = 38;
  logic        m_rw = 1'b0;
  logic [15:0] m_addr = '0;
  logic [7:0]  m_wdata = '0;
  logic [7:0]  m_rbyte = '0;
  logic [7:0]  m_rdata = '0;
  bit          chk_en = 1'b0;

  always @(negedge sck or negedge rst_n) begin
    if (!rst_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      m_rdata  <= '0;
    end else if (m_active && m_k < m_len) begin
      m_k <= m_k + 1;
      if (m_rw && m_k == m_len - 1) m_rdata <= m_rbyte;
    end else if (start) begin
      m_active <= 1'b1;
      m_k      <= 1;
      m_rw     <= rw;
      m_addr   <= addr;
      m_wdata  <= wdata;
      m_rbyte  <= next_rbyte;
      m_len    <= rw ? 37 : 38;
    end else begin
      m_active <= 1'b0;
    end
  end

  function automatic logic [7:0] model_byte(input int b);
    case (b)
      0:       model_byte = m_rw ? 8'h03 : 8'h02;
      1:       model_byte = m_addr[15:8];
      2:       model_byte = m_addr[7:0];
      default: model_byte = m_wdata;
    endcase
  endfunction

  // SRAM read-data model: bit 7-i during the i-th receive cycle (k = 28..35)
  always @(posedge sck) begin
    if (m_active && m_rw && m_k >= 28 && m_k <= 35) sdi <= m_rbyte[35 - m_k];
    else sdi <= 1'($urandom);
  end

  task automatic compare();
    logic       e_busy, e_done, e_cs, e_load, e_shift;
    logic [3:0] e_cnt;
    logic [7:0] e_byte;
    int nb, p, b;
    e_busy = 1'b0; e_done = 1'b0; e_cs = 1'b1; e_load = 1'b0; e_shift = 1'b0;
    e_cnt = '0; e_byte = '0;
    if (m_active) begin
      nb = m_rw ? 3 : 4;
      if (m_k == m_len) begin
        e_done = 1'b1;
      end else begin
        e_busy = 1'b1;
        e_cs   = 1'b0;
        if (m_k <= 9 * nb) begin
          p = (m_k - 1) % 9;
          b = (m_k - 1) / 9;
          if (p == 0) begin
            e_load = 1'b1;
            e_byte = model_byte(b);
          end else begin
            e_shift = 1'b1;
            e_cnt   = 4'(9 - p);
          end
        end
      end
    end
    chk("busy", busy, e_busy);
    chk("done", done, e_done);
    chk("cs_n", cs_n, e_cs);
    chk("load_tx", load_tx, e_load);
    chk("shift_tx", shift_tx, e_shift);
    chk("tx_count", tx_count, e_cnt);
    chk("rdata", rdata, m_rdata);
    if (e_load) chk("tx_byte", tx_byte, e_byte);
  endtask

  always @(posedge sck) begin
    if (chk_en && rst_n === 1'b1) compare();
  end

  // ---------------- directed-scenario recorder ----------------
  bit          rec_on = 1'b0;
  longint      rec_t0 = 0;
  logic [7:0]  ld_byte[$];
  int          ld_cyc[$];
  int          dn_cyc[$];
  logic [7:0]  dn_rdata;
  int          first_lo, last_lo, cs_hi, max_cnt;

  always @(posedge sck) begin : rec_blk
    int c;
    if (rec_on) begin
      c = int'((longint'($time) - rec_t0) / 10);
      if (c > 0) begin
        if (load_tx) begin
          ld_byte.push_back(tx_byte);
          ld_cyc.push_back(c);
        end
        if (done) begin
          dn_cyc.push_back(c);
          dn_rdata = rdata;
        end
        if (!cs_n) begin
          if (first_lo == 0) first_lo = c;
          last_lo = c;
        end else if (c <= 76) begin
          cs_hi++;
        end
        if (int'(tx_count) > max_cnt) max_cnt = int'(tx_count);
      end
    end
  end

  task automatic go(input logic r, input logic [15:0] a, input logic [7:0] w,
                    input logic [7:0] rb, input int hold);
    @(posedge sck);
    rw = r; addr = a; wdata = w; next_rbyte = rb; start = 1'b1;
    ld_byte.delete(); ld_cyc.delete(); dn_cyc.delete();
    dn_rdata = '0; first_lo = 0; last_lo = 0; cs_hi = 0; max_cnt = 0;
    rec_t0 = longint'($time);
    rec_on = 1'b1;
    repeat (hold) @(posedge sck);
    start = 1'b0;
    // Scramble request inputs to prove they were captured with start
    rw = 1'($urandom); addr = 16'($urandom); wdata = 8'($urandom);
  endtask

  task automatic idle_for(input int n);
    repeat (n) @(posedge sck);
    rec_on = 1'b0;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] eb[4], input int n,
                              input int done_c);
    int ecyc[4] = '{1, 10, 19, 28};
    chk({tag, "_nloads"}, ld_byte.size(), n);
    for (int i = 0; i < n && i < ld_byte.size(); i++) begin
      chk({tag, "_byte"}, ld_byte[i], eb[i]);
      chk({tag, "_load_cyc"}, ld_cyc[i], ecyc[i]);
    end
    chk({tag, "_ndone"}, dn_cyc.size(), 1);
    if (dn_cyc.size() > 0) chk({tag, "_done_cyc"}, dn_cyc[0], done_c);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; rw = 1'b0; addr = '0; wdata = '0; sdi = 1'b0;
    repeat (2) @(posedge sck);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_cs_n", cs_n, 1);
    chk("reset_load", load_tx, 0);
    chk("reset_shift", shift_tx, 0);
    chk("reset_count", tx_count, 0);
    chk("reset_tx_byte", tx_byte, 0);
    chk("reset_rdata", rdata, 0);
    @(posedge sck);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    idle_for(2);

    // Write 1234 <- A5
    go(1'b0, 16'h1234, 8'hA5, 8'h00, 1);
    repeat (45) @(posedge sck);
    expect_frame("wr", '{8'h02, 8'h12, 8'h34, 8'hA5}, 4, 38);
    chk("wr_cs_first", first_lo, 1);
    chk("wr_cs_last", last_lo, 37);
    idle_for(2);

    // Read 00FF, SRAM returns 3C
    go(1'b1, 16'h00FF, 8'h77, 8'h3C, 1);
    repeat (45) @(posedge sck);
    expect_frame("rd", '{8'h03, 8'h00, 8'hFF, 8'h00}, 3, 37);
    chk("rd_rdata_at_done", dn_rdata, 8'h3C);
    chk("rd_rdata_hold", rdata, 8'h3C);
    idle_for(2);

    // start pulsed at cycle 5 of a write must be ignored
    go(1'b0, 16'h1234, 8'hA5, 8'h00, 1);
    repeat (4) @(posedge sck);
    start = 1'b1; rw = 1'b1; addr = 16'h5555;
    @(posedge sck);
    start = 1'b0;
    repeat (40) @(posedge sck);
    expect_frame("busy_ign", '{8'h02, 8'h12, 8'h34, 8'hA5}, 4, 38);
    idle_for(2);

    // Reset asserted at cycle 14 (mid-SHIFT)
    go(1'b0, 16'h1234, 8'hA5, 8'h00, 1);
    repeat (13) @(posedge sck);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_shift", shift_tx, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_count", tx_count, 0);
    repeat (3) @(posedge sck);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge sck);
    chk("midrst_no_done", dn_cyc.size(), 0);
    idle_for(1);
    go(1'b0, 16'hBEEF, 8'h11, 8'h00, 1);
    repeat (45) @(posedge sck);
    expect_frame("after_rst", '{8'h02, 8'hBE, 8'hEF, 8'h11}, 4, 38);
    idle_for(2);

    // start held high: two back-to-back writes
    go(1'b0, 16'h0F0F, 8'h5A, 8'h00, 76);
    repeat (5) @(posedge sck);
    chk("b2b_ndone", dn_cyc.size(), 2);
    if (dn_cyc.size() == 2) begin
      chk("b2b_done0", dn_cyc[0], 38);
      chk("b2b_done1", dn_cyc[1], 76);
    end
    chk("b2b_cs_gap", (cs_hi >= 1), 1);
    idle_for(2);

    // Boundary address
    go(1'b0, 16'hFFFF, 8'h00, 8'h00, 1);
    repeat (45) @(posedge sck);
    expect_frame("bound", '{8'h02, 8'hFF, 8'hFF, 8'h00}, 4, 38);
    chk("bound_cnt_max", max_cnt, 8);
    idle_for(2);

    // Randomized traffic with occasional resets, checked by the model
    for (int n = 0; n < 3000; n++) begin
      @(posedge sck);
      if ($urandom_range(0, 599) == 0) begin
        #2 rst_n = 1'b0;
        @(posedge sck);
        #2 rst_n = 1'b1;
      end
      start      = ($urandom_range(0, 7) == 0);
      rw         = 1'($urandom);
      addr       = ($urandom_range(0, 15) == 0) ? 16'hFFFF : 16'($urandom);
      wdata      = 8'($urandom);
      next_rbyte = 8'($urandom);
    end
    start = 1'b0;
    repeat (60) @(posedge sck);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sram_spi_ctrl.md
SRAM_SPI_CTRL -- requirements
Module: sram_spi_ctrl

Interface
REQ-001 The block SHALL run on one clock and have an asynchronous, active-low reset (sck, rst_n).
REQ-002 Parameters SHALL be as follows, one per line: name, default, meaning.
- CMD_READ, 8'h03, SRAM read instruction.
- CMD_WRITE, 8'h02, SRAM write instruction.
REQ-003 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- sck, in, 1, SPI clock; all state changes on the negedge, matching the transmit buffer.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, transaction request; sampled in IDLE only.
- rw, in, 1, 1 = read, 0 = write; captured with start.
- addr, in, 16, SRAM byte address; captured with start.
- wdata, in, 8, write data byte; captured with start.
- sdi, in, 1, serial data from SRAM; MSB first.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse at transaction end.
- rdata, out, 8, read byte; holds value until next read completes.
- cs_n, out, 1, SRAM chip select, active low.
- tx_byte, out, 8, parallel byte to the transmit buffer.
- load_tx, out, 1, transmit buffer load strobe.
- shift_tx, out, 1, transmit buffer shift enable.
- tx_count, out, 4, transmit bit index; valid range 8..1.

Function
REQ-004 The FSM SHALL have these states: IDLE, LOAD, SHIFT, RECV, FINISH.
REQ-005 IDLE with start=1 SHALL do all of the following:
- capture rw, addr and wdata;
- clear the byte index to 0;
- assert busy and drive cs_n low;
- enter LOAD on the next negedge.
REQ-006 In LOAD, for exactly one cycle, the block SHALL drive load_tx=1 and tx_byte = byte[index], then enter SHIFT.
- Byte 0 is CMD_READ or CMD_WRITE, selected by rw.
- Byte 1 is addr[15:8].
- Byte 2 is addr[7:0].
- Byte 3 is wdata.
REQ-007 SHIFT SHALL last 8 cycles, with shift_tx=1 and tx_count stepping 8,7,...,1.
REQ-008 When SHIFT ends with tx_count=1, the next state SHALL be:
- LOAD with index+1, if index < 2, or if index = 2 and rw = 0;
- RECV, if index = 2 and rw = 1;
- FINISH, if index = 3.
REQ-009 RECV SHALL last 8 cycles with shift_tx=0, shifting sdi into an 8-bit register MSB first; on the 8th cycle rdata SHALL update.
REQ-010 FINISH SHALL last one cycle and do all of the following:
- drive cs_n high;
- pulse done;
- deassert busy;
- return to IDLE.
REQ-011 Latency from start-sample edge to done SHALL be 38 cycles for a write (1 + 4×9 + 1) and 37 cycles for a read (1 + 3×9 + 8 + 1).
REQ-012 start SHALL be ignored outside IDLE; it SHALL NOT queue.
REQ-013 start held high through FINISH SHALL begin a new transaction only after one IDLE cycle; cs_n SHALL be high for at least one cycle between transactions.
REQ-014 Outside SHIFT, the block SHALL drive shift_tx=0 and tx_count=0.
REQ-015 Outside LOAD, load_tx SHALL be 0.
REQ-016 addr=16'hFFFF SHALL be transmitted unmodified; no wrap or auto-increment.

Reset
REQ-017 Asserting rst_n=0 SHALL immediately force all of the following, including mid-transaction:
- state to IDLE;
- cs_n=1;
- busy, done, load_tx and shift_tx to 0;
- tx_count=0, tx_byte=0, rdata=0.
REQ-018 A transaction interrupted by reset SHALL NOT produce done; the first transaction after reset SHALL start from byte 0.

Structure
REQ-019 The shared package sram_spi_pkg SHALL hold:
- CMD_READ and CMD_WRITE values;
- state encodings;
- the byte count (4) and bit count (8).
REQ-020 The receive shifter SHALL be one sub-module, spi_rx_shift, with inputs sck, rst_n, en, sdi and output an 8-bit data value.
REQ-021 The transmit buffer SHALL remain external; this block drives only its control and data inputs.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Write: rw=0, addr=16'h1234, wdata=8'hA5 -> tx_byte sequence 02,12,34,A5; load_tx pulses at cycles 1,10,19,28; done at cycle 38; cs_n low for cycles 1..37.
- Read: rw=1, addr=16'h00FF, sdi model returns 8'h3C -> tx_byte sequence 03,00,FF; rdata=8'h3C at done, cycle 37.
- Busy ignore: start pulsed at cycle 5 of a write -> no restart; tx_byte sequence unchanged; a single done.
- Reset mid-SHIFT: rst_n low at cycle 14 -> cs_n=1 and shift_tx=0 immediately; no done; next start emits 02 first.
- Back-to-back: start held high -> cs_n high for ≥1 cycle between transactions; exactly two done pulses in 2×38+1 cycles.
- Boundary: addr=16'hFFFF, wdata=8'h00 -> bytes 02,FF,FF,00; tx_count never outside 0..8.
